// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the Common Data Bus: picks at most one completed
// functional-unit result per cycle and registers it onto the broadcast bus.
module cdb_arbiter #(
    parameter int NUM_FU = 5,
    parameter int TAG_W  = 8,
    parameter int DATA_W = 32,
    parameter int PTR_W  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NUM_FU-1:0]        fu_valid,
    input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
    input  logic [NUM_FU*DATA_W-1:0] fu_data,
    output logic [NUM_FU-1:0]        fu_grant,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_rs_num,
    output logic [DATA_W-1:0]        cdb_data,
    output logic                     err_zero_tag
);

    // Handshake: a transfer happens at a rising edge where fu_valid[i] & fu_grant[i];
    // the FU holds valid/tag/data stable until then and never derives valid from grant.

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_FU - 1);

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_rs_num_q, cdb_rs_num_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
    logic              err_zero_tag_q, err_zero_tag_d;

    logic              found;
    logic [PTR_W-1:0]  sel;
    logic [PTR_W-1:0]  idx;
    logic [TAG_W-1:0]  sel_tag;
    logic [DATA_W-1:0] sel_data;

    // Scan from rr_ptr upward, wrapping at NUM_FU; first valid requester wins.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = rr_ptr_q;
        for (int k = 0; k < NUM_FU; k++) begin
            if (!found && fu_valid[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
            idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
        if (rst || flush) begin
            found = 1'b0;
        end
        fu_grant = '0;
        if (found) begin
            fu_grant[sel] = 1'b1;
        end
        sel_tag  = fu_tag[int'(sel)*TAG_W +: TAG_W];
        sel_data = fu_data[int'(sel)*DATA_W +: DATA_W];
    end

    always_comb begin
        cdb_valid_d    = 1'b0;
        cdb_rs_num_d   = '0;
        cdb_data_d     = '0;
        err_zero_tag_d = err_zero_tag_q;
        rr_ptr_d       = rr_ptr_q;
        if (flush) begin
            rr_ptr_d = '0;
        end else if (found) begin
            rr_ptr_d = (sel == LAST_IDX) ? '0 : sel + 1'b1;
            // A zero tag means "no producer": consume it but never broadcast it.
            if (sel_tag != '0) begin
                cdb_valid_d  = 1'b1;
                cdb_rs_num_d = sel_tag;
                cdb_data_d   = sel_data;
            end else begin
                err_zero_tag_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q       <= '0;
            cdb_valid_q    <= 1'b0;
            cdb_rs_num_q   <= '0;
            cdb_data_q     <= '0;
            err_zero_tag_q <= 1'b0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            cdb_valid_q    <= cdb_valid_d;
            cdb_rs_num_q   <= cdb_rs_num_d;
            cdb_data_q     <= cdb_data_d;
            err_zero_tag_q <= err_zero_tag_d;
        end
    end

    assign cdb_valid    = cdb_valid_q;
    assign cdb_rs_num   = cdb_rs_num_q;
    assign cdb_data     = cdb_data_q;
    assign err_zero_tag = err_zero_tag_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: table of grant vectors with a CDB scoreboard queue,
// followed by hand-written zero-tag and mid-broadcast reset sequences.
module tb_cdb_arbiter;

    localparam int NUM_FU = 5;
    localparam int TAG_W  = 8;
    localparam int DATA_W = 32;
    localparam int PTR_W  = 3;
    localparam int CDB_W  = 1 + TAG_W + DATA_W;

    logic                     clk;
    logic                     rst;
    logic                     flush;
    logic [NUM_FU-1:0]        fu_valid;
    logic [NUM_FU*TAG_W-1:0]  fu_tag;
    logic [NUM_FU*DATA_W-1:0] fu_data;
    logic [NUM_FU-1:0]        fu_grant;
    logic                     cdb_valid;
    logic [TAG_W-1:0]         cdb_rs_num;
    logic [DATA_W-1:0]        cdb_data;
    logic                     err_zero_tag;

    int checks;
    int errors;
    logic [CDB_W-1:0] exp_q[$];

    typedef struct {
        logic              flush;
        logic [NUM_FU-1:0] valid;
        logic [NUM_FU-1:0] exp_grant;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vec[NVEC];

    cdb_arbiter #(
        .NUM_FU(NUM_FU), .TAG_W(TAG_W), .DATA_W(DATA_W), .PTR_W(PTR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .fu_valid(fu_valid),
        .fu_tag(fu_tag),
        .fu_data(fu_data),
        .fu_grant(fu_grant),
        .cdb_valid(cdb_valid),
        .cdb_rs_num(cdb_rs_num),
        .cdb_data(cdb_data),
        .err_zero_tag(err_zero_tag)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [TAG_W-1:0] tag_of(input int i);
        return TAG_W'(33 * (i + 1));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic pop_check(input string name);
        logic [CDB_W-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s act=queue_empty exp=entry", name);
        end else begin
            e = exp_q.pop_front();
            check(name, 64'({cdb_valid, cdb_rs_num, cdb_data}), 64'(e));
        end
    endtask

    // driver: FU i always carries tag_of(i) with fresh random data
    task automatic drive(input logic fl, input logic [NUM_FU-1:0] v);
        flush    = fl;
        fu_valid = v;
        for (int i = 0; i < NUM_FU; i++) begin
            fu_tag[i*TAG_W +: TAG_W]    = tag_of(i);
            fu_data[i*DATA_W +: DATA_W] = $urandom_range(32'hFFFF_FFFF, 0);
        end
    endtask

    // expected bus contents one edge after the given grant
    task automatic push_expected(input logic [NUM_FU-1:0] g);
        logic [CDB_W-1:0] e;
        e = '0;
        for (int j = 0; j < NUM_FU; j++) begin
            if (g[j] && tag_of(j) != '0) begin
                e = {1'b1, tag_of(j), fu_data[j*DATA_W +: DATA_W]};
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic idle();
        flush    = 1'b0;
        fu_valid = '0;
        fu_tag   = '0;
        fu_data  = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle();

        vec[0]  = '{1'b0, 5'b11111, 5'b00001};
        vec[1]  = '{1'b0, 5'b11111, 5'b00010};
        vec[2]  = '{1'b0, 5'b11111, 5'b00100};
        vec[3]  = '{1'b0, 5'b11111, 5'b01000};
        vec[4]  = '{1'b0, 5'b11111, 5'b10000};
        vec[5]  = '{1'b0, 5'b11111, 5'b00001};
        vec[6]  = '{1'b0, 5'b00000, 5'b00000};
        vec[7]  = '{1'b0, 5'b00100, 5'b00100};
        vec[8]  = '{1'b0, 5'b00000, 5'b00000};
        vec[9]  = '{1'b0, 5'b01000, 5'b01000};
        vec[10] = '{1'b0, 5'b01010, 5'b00010};
        vec[11] = '{1'b0, 5'b01010, 5'b01000};
        vec[12] = '{1'b1, 5'b00011, 5'b00000};
        vec[13] = '{1'b0, 5'b00011, 5'b00001};
        vec[14] = '{1'b0, 5'b00011, 5'b00010};
        vec[15] = '{1'b0, 5'b10001, 5'b10000};
        vec[16] = '{1'b0, 5'b10001, 5'b00001};

        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", 64'(fu_grant), 64'(0));
        check("rst_cdb", 64'({cdb_valid, cdb_rs_num, cdb_data}), 64'(0));
        check("rst_err", 64'(err_zero_tag), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < NVEC; v++) begin
            @(posedge clk);
            #1;
            if (v > 0) pop_check($sformatf("cdb_v%0d", v - 1));
            drive(vec[v].flush, vec[v].valid);
            @(negedge clk);
            check($sformatf("grant_v%0d", v), 64'(fu_grant), 64'(vec[v].exp_grant));
            push_expected(vec[v].exp_grant);
        end
        @(posedge clk);
        #1;
        pop_check($sformatf("cdb_v%0d", NVEC - 1));
        idle();
        check("err_clean", 64'(err_zero_tag), 64'(0));

        // zero tag: pointer is 1, FU3 alone requests with tag 0
        @(negedge clk);
        fu_valid = 5'b01000;
        fu_tag[3*TAG_W +: TAG_W]    = 8'h00;
        fu_data[3*DATA_W +: DATA_W] = 32'h0000_1234;
        #1;
        check("zt_grant", 64'(fu_grant), 64'(5'b01000));
        @(posedge clk);
        #1;
        idle();
        check("zt_cdb", 64'({cdb_valid, cdb_rs_num, cdb_data}), 64'(0));
        check("zt_err", 64'(err_zero_tag), 64'(1));
        repeat (3) @(posedge clk);
        #1;
        check("zt_err_sticky", 64'(err_zero_tag), 64'(1));

        // reset mid-broadcast: pointer is 4, FU1 carries tag 8'h22
        @(negedge clk);
        fu_valid = 5'b00010;
        fu_tag[1*TAG_W +: TAG_W]    = 8'h22;
        fu_data[1*DATA_W +: DATA_W] = 32'hCAFE_0022;
        #1;
        check("rb_grant", 64'(fu_grant), 64'(5'b00010));
        @(posedge clk);
        #1;
        check("rb_cdb", 64'({cdb_valid, cdb_rs_num, cdb_data}), 64'({1'b1, 8'h22, 32'hCAFE_0022}));
        drive(1'b0, 5'b11111);
        #1;
        rst = 1'b1;
        #1;
        check("rb_cdb_clr", 64'({cdb_valid, cdb_rs_num, cdb_data}), 64'(0));
        check("rb_err_clr", 64'(err_zero_tag), 64'(0));
        check("rb_grant_rst", 64'(fu_grant), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rb_first_grant", 64'(fu_grant), 64'(5'b00001));
        push_expected(5'b00001);
        @(posedge clk);
        #1;
        pop_check("rb_first_cdb");
        idle();
        @(posedge clk);
        #1;
        check("idle_cdb", 64'({cdb_valid, cdb_rs_num, cdb_data}), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single Common Data Bus between the Tomasulo functional units (ALU, JUMP, LSU, MUL, DIV reservation-station groups).
- Each cycle it selects at most one completed result by round-robin and registers it onto the CDB.
- The CDB feeds the register file's broadcast inputs (cdb_rs_num / cdb_data) and all reservation stations.
- A zero tag means "no producer/idle" throughout the design.

Parameters:
- NUM_FU, default 5: number of requesting functional units; legal range 2..8.
- TAG_W, default 8: tag width, bits [7:5] FU type, bits [4:0] RS number.
- DATA_W, default 32: result width.
- PTR_W, default 3: round-robin pointer width; must satisfy 2^PTR_W >= NUM_FU.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous squash: no grants this cycle, bus cleared next edge.
- fu_valid  in  NUM_FU  bit i: FU i holds a completed result.
- fu_tag  in  NUM_FU*TAG_W  slice i = tag of FU i's result.
- fu_data  in  NUM_FU*DATA_W  slice i = result of FU i.
- fu_grant  out  NUM_FU  one-hot (or zero), combinational: FU i's result is taken this cycle.
- cdb_valid  out  1  registered: a broadcast is on the bus.
- cdb_rs_num  out  TAG_W  registered broadcast tag; 0 when idle.
- cdb_data  out  DATA_W  registered broadcast data; 0 when idle.
- err_zero_tag  out  1  sticky: a valid request carried tag 0.

Behaviour:
- Reset (async, rst=1):
  - cdb_valid=0, cdb_rs_num=0, cdb_data=0, err_zero_tag=0, rr_ptr=0.
  - fu_grant=0 while rst is high.
- Handshake: valid/grant.
  - FU i holds fu_valid[i], tag and data stable until it sees fu_valid[i] & fu_grant[i] at a rising edge; the transfer occurs at that edge.
  - FU may drop and re-raise valid on the next cycle with a new result.
  - fu_valid may not depend combinationally on fu_grant.
- Selection (combinational):
  - Scan indices rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_FU.
  - The first i with fu_valid[i]=1 gets fu_grant[i]=1; all other grant bits are 0.
  - No valid request, flush=1, or rst=1: fu_grant=0.
  - At most one grant bit is ever high.
- Registered update at each rising edge with no flush:
  - Grant to i with tag!=0: cdb_valid<=1, cdb_rs_num<=tag_i, cdb_data<=data_i.
  - Grant to i with tag==0: the request is consumed; cdb_valid<=0, cdb_rs_num<=0, cdb_data<=0, err_zero_tag<=1 (held until reset).
  - No grant: cdb_valid<=0, cdb_rs_num<=0, cdb_data<=0.
  - rr_ptr <= (i==NUM_FU-1) ? 0 : i+1 after a grant; unchanged when no grant.
- Latency:
  - Result visible on the CDB exactly 1 cycle after the grant edge.
  - Each broadcast lasts exactly 1 cycle.
  - Back-to-back broadcasts are allowed every cycle.
- Fairness: any continuously valid FU is granted within NUM_FU cycles.
- Flush: fu_grant=0 that cycle; at the edge cdb_valid/cdb_rs_num/cdb_data<=0 and rr_ptr<=0; err_zero_tag is unaffected.
- Reset mid-broadcast: outputs clear immediately (async); a pending un-granted request is not remembered; FUs are reset by the same rst.
- Simultaneous all-valid: grants cycle rr_ptr order, one per cycle.
- Pointer wrap: after granting index NUM_FU-1, rr_ptr wraps to 0.
- Pipeline: no internal buffering beyond the output register; the bus is never back-pressured.

Test Plan:
- Reset: assert rst mid-cycle while cdb_valid=1, cdb_rs_num=8'h22 -> all outputs 0 immediately; after release, first grant goes to FU0.
- Single requester: FU2 valid, tag 8'h43, data 32'hDEADBEEF -> fu_grant=5'b00100 that cycle; next cycle cdb_valid=1, cdb_rs_num=8'h43, cdb_data=32'hDEADBEEF; the following cycle all outputs 0 if FU2 drops valid.
- Round-robin with all 5 valid held, tags 8'h21, 8'h42, 8'h63, 8'h84, 8'hA5, starting at rr_ptr=0 -> grants FU0..FU4 on consecutive cycles; CDB tags 21,42,63,84,A5; 6th grant returns to FU0.
- Wrap and skip: rr_ptr=4, only FU1 and FU3 valid -> FU1 granted first, rr_ptr=2; next cycle FU3 granted, rr_ptr=4.
- Flush: FU0 and FU1 valid, flush=1 for one cycle -> fu_grant=0, CDB 0, rr_ptr=0; next cycle FU0 granted.
- Zero tag: FU3 valid with tag 8'h00, data 32'h1234 -> fu_grant[3]=1, next cycle cdb_valid=0, cdb_rs_num=0, err_zero_tag=1 and stays 1 until rst.
